// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath (slave).
// Carries the IR opcode, ALU/memory status and every datapath control line.
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_en;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_source;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
               mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, illegal_op, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
               mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, illegal_op, instr_count
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle MIPS-subset datapath: fetch/decode/execute/memory/writeback.
// Optional BNE_SUPPORT_EN macro adds opcode 000101 (BNE) as a branch taken on ~zero.
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    multicycle_control_fsm_if.master ctrl
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef BNE_SUPPORT_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] count_reg;
    logic             illegal_reg;
    logic             illegal_next;
    logic             retire;
    logic             branch_taken;

`ifdef BNE_SUPPORT_EN
    // The opcode is not sampled in BRANCH, so the branch sense is latched at decode.
    logic bne_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bne_reg <= 1'b0;
        end else if (state_reg == S_DECODE) begin
            bne_reg <= (ctrl.opcode == OP_BNE);
        end
    end

    assign branch_taken = bne_reg ? ~ctrl.zero : ctrl.zero;
`else
    assign branch_taken = ctrl.zero;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
            if (retire) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = S_FETCH;
        illegal_next = 1'b0;
        retire       = 1'b0;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = ctrl.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctrl.opcode)
                    OP_R:    state_next = S_EXEC;
                    OP_LW:   state_next = S_MEMADR;
                    OP_SW:   state_next = S_MEMADR;
                    OP_BEQ:  state_next = S_BRANCH;
`ifdef BNE_SUPPORT_EN
                    OP_BNE:  state_next = S_BRANCH;
`endif
                    OP_J:    state_next = S_JUMP;
                    OP_ADDI: state_next = S_ADDIEX;
                    default: begin
                        state_next   = S_FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_next = (ctrl.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = ctrl.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                state_next = ctrl.mem_ready ? S_FETCH : S_MEMWR;
                retire     = ctrl.mem_ready;
            end
            S_EXEC:   state_next = S_ALUWB;
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            default:  state_next = S_FETCH;
        endcase
    end

    // Moore outputs; only the FETCH write enables look at mem_ready directly.
    always_comb begin
        ctrl.pc_write      = 1'b0;
        ctrl.pc_write_cond = 1'b0;
        ctrl.pc_source     = 2'b00;
        ctrl.i_or_d        = 1'b0;
        ctrl.mem_read      = 1'b0;
        ctrl.mem_write     = 1'b0;
        ctrl.ir_write      = 1'b0;
        ctrl.mem_to_reg    = 1'b0;
        ctrl.reg_dst       = 1'b0;
        ctrl.reg_write     = 1'b0;
        ctrl.alu_src_a     = 1'b0;
        ctrl.alu_src_b     = 2'b00;
        ctrl.alu_op        = 2'b00;
        case (state_reg)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = ctrl.mem_ready;
                ctrl.pc_write  = ctrl.mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
            default: ;
        endcase
    end

    assign ctrl.pc_en       = ctrl.pc_write | (ctrl.pc_write_cond & branch_taken);
    assign ctrl.illegal_op  = illegal_reg;
    assign ctrl.instr_count = count_reg;

endmodule
